// File: rtl/axil2ahb_rr_pkg.sv
// Shared types and encodings for the axil2ahb_rr AXI4-Lite to AHB-Lite bridge.
package axil2ahb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    function automatic logic [2:0] hsize_full(input int dwidth);
        return (dwidth == 64) ? HSIZE_DWORD : HSIZE_WORD;
    endfunction

endpackage

// File: rtl/axil2ahb_rr_if.sv
// AXI4-Lite slave and AHB-Lite master signal bundle of axil2ahb_rr.
// The slave modport is the bridge side, the master modport the environment side.
interface axil2ahb_rr_if #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 32
);
    logic [AWIDTH-1:0]   axil_awaddr;
    logic [2:0]          axil_awprot;
    logic                axil_awvalid;
    logic                axil_awready;
    logic [DWIDTH-1:0]   axil_wdata;
    logic [DWIDTH/8-1:0] axil_wstrb;
    logic                axil_wvalid;
    logic                axil_wready;
    logic [1:0]          axil_bresp;
    logic                axil_bvalid;
    logic                axil_bready;
    logic [AWIDTH-1:0]   axil_araddr;
    logic [2:0]          axil_arprot;
    logic                axil_arvalid;
    logic                axil_arready;
    logic [DWIDTH-1:0]   axil_rdata;
    logic [1:0]          axil_rresp;
    logic                axil_rvalid;
    logic                axil_rready;

    logic [AWIDTH-1:0]   haddr;
    logic [DWIDTH-1:0]   hwdata;
    logic                hsel;
    logic                hwrite;
    logic [1:0]          htrans;
    logic [2:0]          hsize;
    logic                hready;
    logic [DWIDTH-1:0]   hrdata;
    logic [1:0]          hresp;

    modport slave (
        input  axil_awaddr, axil_awprot, axil_awvalid,
        output axil_awready,
        input  axil_wdata, axil_wstrb, axil_wvalid,
        output axil_wready,
        output axil_bresp, axil_bvalid,
        input  axil_bready,
        input  axil_araddr, axil_arprot, axil_arvalid,
        output axil_arready,
        output axil_rdata, axil_rresp, axil_rvalid,
        input  axil_rready,
        output haddr, hwdata, hsel, hwrite, htrans, hsize,
        input  hready, hrdata, hresp
    );

    modport master (
        output axil_awaddr, axil_awprot, axil_awvalid,
        input  axil_awready,
        output axil_wdata, axil_wstrb, axil_wvalid,
        input  axil_wready,
        input  axil_bresp, axil_bvalid,
        output axil_bready,
        output axil_araddr, axil_arprot, axil_arvalid,
        input  axil_arready,
        input  axil_rdata, axil_rresp, axil_rvalid,
        output axil_rready,
        input  haddr, hwdata, hsel, hwrite, htrans, hsize,
        output hready, hrdata, hresp
    );
endinterface

// File: rtl/axil2ahb_strb_decode.sv
// Maps a write strobe to an AHB transfer size and byte offset; flags all-zero
// strobes and patterns that are not a naturally aligned power-of-two run.
module axil2ahb_strb_decode
    import axil2ahb_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH/8-1:0]         wstrb_i,
    output logic                        legal_o,
    output logic                        zero_o,
    output logic [2:0]                  hsize_o,
    output logic [$clog2(DWIDTH/8)-1:0] offset_o
);
    localparam int NB   = DWIDTH / 8;
    localparam int OFFW = $clog2(NB);

    logic [3:0]      cnt_s;
    logic [OFFW-1:0] low_s;
    logic            found_s;
    logic            pow2_s;
    logic [NB-1:0]   mask_s;
    logic [2:0]      size_s;

    // Byte count and index of the lowest enabled lane
    always_comb begin
        cnt_s   = 4'd0;
        low_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < NB; i++) begin
            cnt_s = cnt_s + {3'b000, wstrb_i[i]};
            if (wstrb_i[i] && !found_s) begin
                low_s   = OFFW'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Contiguous mask implied by count/offset, and the size for that count
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < NB; i++) begin
            mask_s[i] = (i >= int'(low_s)) && (i < int'(low_s) + int'(cnt_s));
        end
        case (cnt_s)
            4'd1: begin pow2_s = 1'b1; size_s = HSIZE_BYTE;  end
            4'd2: begin pow2_s = 1'b1; size_s = HSIZE_HALF;  end
            4'd4: begin pow2_s = 1'b1; size_s = HSIZE_WORD;  end
            4'd8: begin pow2_s = 1'b1; size_s = HSIZE_DWORD; end
            default: begin pow2_s = 1'b0; size_s = HSIZE_BYTE; end
        endcase
    end

    assign zero_o   = (wstrb_i == '0);
    assign legal_o  = pow2_s && (mask_s == wstrb_i) &&
                      ((low_s & OFFW'(cnt_s - 4'd1)) == '0);
    assign hsize_o  = size_s;
    assign offset_o = low_s;

endmodule

// File: rtl/axil2ahb_rr.sv
// AXI4-Lite slave to AHB-Lite master bridge with one-deep AW/W/AR hold slots
// and round-robin read/write arbitration. Optional watchdog: AXIL2AHB_TIMEOUT_EN.
module axil2ahb_rr
    import axil2ahb_pkg::*;
#(
    parameter int AWIDTH         = 16,
    parameter int DWIDTH         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic          clk,
    input logic          rst_n,
    axil2ahb_rr_if.slave bus
);
    localparam int         NB         = DWIDTH / 8;
    localparam int         OFFW       = $clog2(NB);
    localparam logic [2:0] HSIZE_FULL = hsize_full(DWIDTH);

    // Hold slots; each ready flag doubles as the "slot empty" indicator
    logic                 awready_q, wready_q, arready_q;
    logic [AWIDTH-1:OFFW] aw_addr_q, ar_addr_q;
    logic [DWIDTH-1:0]    w_data_q;
    logic [NB-1:0]        w_strb_q;

    state_e               state_q;
    logic                 last_write_q;
    logic                 cur_write_q;
    logic [AWIDTH-1:0]    haddr_q;
    logic [DWIDTH-1:0]    hwdata_q;
    logic                 hsel_q, hwrite_q;
    logic [1:0]           htrans_q;
    logic [2:0]           hsize_q;
    logic                 bvalid_q, rvalid_q;
    logic [1:0]           bresp_q, rresp_q;
    logic [DWIDTH-1:0]    rdata_q;

    logic                 dec_legal_s, dec_zero_s;
    logic [2:0]           dec_hsize_s;
    logic [OFFW-1:0]      dec_off_s;
    logic                 wr_elig_s, rd_elig_s, contend_s;
    logic                 wr_grant_s, rd_grant_s, no_xfer_s;
    logic                 busy_s, done_s, timeout_s;
    logic                 free_w_s, free_r_s;
    logic [1:0]           resp_s;
    logic [DWIDTH-1:0]    rdata_s;
    logic                 unused_s;

    axil2ahb_strb_decode #(.DWIDTH(DWIDTH)) u_strb_decode (
        .wstrb_i  (w_strb_q),
        .legal_o  (dec_legal_s),
        .zero_o   (dec_zero_s),
        .hsize_o  (dec_hsize_s),
        .offset_o (dec_off_s)
    );

    assign busy_s = (state_q == ST_ADDR) || (state_q == ST_DATA);

`ifdef AXIL2AHB_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] to_cnt_q;

    assign timeout_s = busy_s && !bus.hready &&
                       (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1));

    // Consecutive wait-state counter for the transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (busy_s && !bus.hready && !timeout_s) begin
            to_cnt_q <= to_cnt_q + TOW'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Arbitration, completion and slot-release decode
    always_comb begin
        wr_elig_s = !awready_q && !wready_q;
        rd_elig_s = !arready_q;
        contend_s = wr_elig_s && rd_elig_s;
        if (state_q == ST_IDLE) begin
            wr_grant_s = wr_elig_s && (!rd_elig_s || !last_write_q);
            rd_grant_s = rd_elig_s && !wr_grant_s;
        end else begin
            wr_grant_s = 1'b0;
            rd_grant_s = 1'b0;
        end
        no_xfer_s = dec_zero_s || !dec_legal_s;
        done_s    = ((state_q == ST_DATA) && bus.hready) || timeout_s;
        if (timeout_s || (bus.hresp != 2'b00)) begin
            resp_s = AXI_RESP_SLVERR;
        end else begin
            resp_s = AXI_RESP_OKAY;
        end
        rdata_s  = timeout_s ? '0 : bus.hrdata;
        free_w_s = (wr_grant_s && no_xfer_s) || (done_s && cur_write_q);
        free_r_s = done_s && !cur_write_q;
    end

    // Hold-slot capture and release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            arready_q <= 1'b1;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (awready_q && bus.axil_awvalid) begin
                aw_addr_q <= bus.axil_awaddr[AWIDTH-1:OFFW];
                awready_q <= 1'b0;
            end else if (free_w_s) begin
                awready_q <= 1'b1;
            end else begin
                awready_q <= awready_q;
            end
            if (wready_q && bus.axil_wvalid) begin
                w_data_q <= bus.axil_wdata;
                w_strb_q <= bus.axil_wstrb;
                wready_q <= 1'b0;
            end else if (free_w_s) begin
                wready_q <= 1'b1;
            end else begin
                wready_q <= wready_q;
            end
            if (arready_q && bus.axil_arvalid) begin
                ar_addr_q <= bus.axil_araddr[AWIDTH-1:OFFW];
                arready_q <= 1'b0;
            end else if (free_r_s) begin
                arready_q <= 1'b1;
            end else begin
                arready_q <= arready_q;
            end
        end
    end

    // Transfer FSM; every AHB and AXI response output is a register here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_write_q <= 1'b0;
            cur_write_q  <= 1'b0;
            haddr_q      <= '0;
            hwdata_q     <= '0;
            hsel_q       <= 1'b0;
            hwrite_q     <= 1'b0;
            htrans_q     <= HTRANS_IDLE;
            hsize_q      <= HSIZE_FULL;
            bvalid_q     <= 1'b0;
            bresp_q      <= AXI_RESP_OKAY;
            rvalid_q     <= 1'b0;
            rresp_q      <= AXI_RESP_OKAY;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The round-robin flag only moves when both sides competed
                    if (contend_s) begin
                        last_write_q <= wr_grant_s;
                    end else begin
                        last_write_q <= last_write_q;
                    end
                    if (wr_grant_s) begin
                        cur_write_q <= 1'b1;
                        if (no_xfer_s) begin
                            bresp_q  <= dec_zero_s ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                            bvalid_q <= 1'b1;
                            state_q  <= ST_RESP;
                        end else begin
                            haddr_q  <= {aw_addr_q, dec_off_s};
                            hsize_q  <= dec_hsize_s;
                            hwrite_q <= 1'b1;
                            hwdata_q <= w_data_q;
                            htrans_q <= HTRANS_NONSEQ;
                            hsel_q   <= 1'b1;
                            state_q  <= ST_ADDR;
                        end
                    end else if (rd_grant_s) begin
                        cur_write_q <= 1'b0;
                        haddr_q     <= {ar_addr_q, {OFFW{1'b0}}};
                        hsize_q     <= HSIZE_FULL;
                        hwrite_q    <= 1'b0;
                        htrans_q    <= HTRANS_NONSEQ;
                        hsel_q      <= 1'b1;
                        state_q     <= ST_ADDR;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (done_s) begin
                        htrans_q <= HTRANS_IDLE;
                        hsel_q   <= 1'b0;
                        if (cur_write_q) begin
                            bresp_q  <= resp_s;
                            bvalid_q <= 1'b1;
                        end else begin
                            rresp_q  <= resp_s;
                            rdata_q  <= rdata_s;
                            rvalid_q <= 1'b1;
                        end
                        state_q <= ST_RESP;
                    end else if ((state_q == ST_ADDR) && bus.hready) begin
                        htrans_q <= HTRANS_IDLE;
                        hsel_q   <= 1'b0;
                        state_q  <= ST_DATA;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_RESP: begin
                    if (bvalid_q && bus.axil_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (rvalid_q && bus.axil_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.axil_awready = awready_q;
    assign bus.axil_wready  = wready_q;
    assign bus.axil_arready = arready_q;
    assign bus.axil_bvalid  = bvalid_q;
    assign bus.axil_bresp   = bresp_q;
    assign bus.axil_rvalid  = rvalid_q;
    assign bus.axil_rresp   = rresp_q;
    assign bus.axil_rdata   = rdata_q;
    assign bus.haddr        = haddr_q;
    assign bus.hwdata       = hwdata_q;
    assign bus.hsel         = hsel_q;
    assign bus.hwrite       = hwrite_q;
    assign bus.htrans       = htrans_q;
    assign bus.hsize        = hsize_q;

    // Protection bits and sub-lane address bits carry no meaning for this bridge
    assign unused_s = ^{bus.axil_awprot, bus.axil_arprot,
                        bus.axil_awaddr[OFFW-1:0], bus.axil_araddr[OFFW-1:0],
                        32'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_axil2ahb_rr.sv
// Directed self-checking bench for axil2ahb_rr (DWIDTH=32); the watchdog
// section runs only when AXIL2AHB_TIMEOUT_EN is defined.
module tb_axil2ahb_rr;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    axil2ahb_rr_if #(.AWIDTH(16), .DWIDTH(32)) bus_if ();

    axil2ahb_rr #(.AWIDTH(16), .DWIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        bus_if.axil_awaddr = 16'h0000; bus_if.axil_awprot = 3'd0; bus_if.axil_awvalid = 1'b0;
        bus_if.axil_wdata = 32'h0; bus_if.axil_wstrb = 4'h0; bus_if.axil_wvalid = 1'b0;
        bus_if.axil_bready = 1'b0;
        bus_if.axil_araddr = 16'h0000; bus_if.axil_arprot = 3'd0; bus_if.axil_arvalid = 1'b0;
        bus_if.axil_rready = 1'b0;
        bus_if.hready = 1'b1; bus_if.hrdata = 32'h0; bus_if.hresp = 2'b00;
        step(2);
        rst_n = 1'b1;

        // Reset state
        chk("rst_bvalid", bus_if.axil_bvalid, 1'b0);
        chk("rst_rvalid", bus_if.axil_rvalid, 1'b0);
        chk("rst_hsel", bus_if.hsel, 1'b0);
        chk("rst_htrans", bus_if.htrans, 2'b00);
        chk("rst_haddr", bus_if.haddr, 16'h0000);
        chk("rst_hsize", bus_if.hsize, 3'b010);
        chk("rst_rdata", bus_if.axil_rdata, 32'h0);
        chk("rst_ready", {bus_if.axil_awready, bus_if.axil_wready, bus_if.axil_arready}, 3'b111);
        step(1);

        // Full-word write, AW and W together
        bus_if.axil_awaddr = 16'h0100; bus_if.axil_awvalid = 1'b1;
        bus_if.axil_wdata = 32'h11223344; bus_if.axil_wstrb = 4'hF; bus_if.axil_wvalid = 1'b1;
        step(1);
        bus_if.axil_awvalid = 1'b0; bus_if.axil_wvalid = 1'b0;
        chk("w1_awready_held", bus_if.axil_awready, 1'b0);
        step(1);
        chk("w1_htrans", bus_if.htrans, 2'b10);
        chk("w1_hsel", bus_if.hsel, 1'b1);
        chk("w1_haddr", bus_if.haddr, 16'h0100);
        chk("w1_hsize", bus_if.hsize, 3'b010);
        chk("w1_hwrite", bus_if.hwrite, 1'b1);
        step(1);
        chk("w1_htrans_one_cycle", bus_if.htrans, 2'b00);
        chk("w1_hwdata", bus_if.hwdata, 32'h11223344);
        chk("w1_bvalid_early", bus_if.axil_bvalid, 1'b0);
        step(1);
        chk("w1_bvalid", bus_if.axil_bvalid, 1'b1);
        chk("w1_bresp", bus_if.axil_bresp, 2'b00);
        chk("w1_awready_freed", bus_if.axil_awready, 1'b1);
        bus_if.axil_bready = 1'b1;
        step(1);
        chk("w1_bvalid_done", bus_if.axil_bvalid, 1'b0);

        // Byte write, W three cycles ahead of AW
        bus_if.axil_wdata = 32'h00AB0000; bus_if.axil_wstrb = 4'h4; bus_if.axil_wvalid = 1'b1;
        step(1);
        bus_if.axil_wvalid = 1'b0;
        step(2);
        bus_if.axil_awaddr = 16'h0200; bus_if.axil_awvalid = 1'b1;
        step(1);
        bus_if.axil_awvalid = 1'b0;
        step(1);
        chk("w2_htrans", bus_if.htrans, 2'b10);
        chk("w2_haddr", bus_if.haddr, 16'h0202);
        chk("w2_hsize", bus_if.hsize, 3'b000);
        step(2);
        chk("w2_bvalid", bus_if.axil_bvalid, 1'b1);
        chk("w2_bresp", bus_if.axil_bresp, 2'b00);
        step(1);

        // Illegal strobe 0101: no AHB transfer, SLVERR
        bus_if.axil_awaddr = 16'h0300; bus_if.axil_awvalid = 1'b1;
        bus_if.axil_wstrb = 4'h5; bus_if.axil_wvalid = 1'b1;
        step(1);
        bus_if.axil_awvalid = 1'b0; bus_if.axil_wvalid = 1'b0;
        step(1);
        chk("w3_no_nonseq", bus_if.htrans, 2'b00);
        chk("w3_bvalid", bus_if.axil_bvalid, 1'b1);
        chk("w3_bresp", bus_if.axil_bresp, 2'b10);
        step(1);
        chk("w3_no_nonseq_after", bus_if.htrans, 2'b00);

        // Zero strobe: no AHB transfer, OKAY
        bus_if.axil_awaddr = 16'h0304; bus_if.axil_awvalid = 1'b1;
        bus_if.axil_wstrb = 4'h0; bus_if.axil_wvalid = 1'b1;
        step(1);
        bus_if.axil_awvalid = 1'b0; bus_if.axil_wvalid = 1'b0;
        step(1);
        chk("w4_no_nonseq", bus_if.htrans, 2'b00);
        chk("w4_bvalid", bus_if.axil_bvalid, 1'b1);
        chk("w4_bresp", bus_if.axil_bresp, 2'b00);
        step(1);

        // Arbitration from a fresh reset: write first, then read
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        bus_if.hrdata = 32'h12345678; bus_if.axil_rready = 1'b1;
        bus_if.axil_awaddr = 16'h0400; bus_if.axil_awvalid = 1'b1;
        bus_if.axil_wdata = 32'hCAFEF00D; bus_if.axil_wstrb = 4'hF; bus_if.axil_wvalid = 1'b1;
        bus_if.axil_araddr = 16'h0500; bus_if.axil_arvalid = 1'b1;
        step(1);
        bus_if.axil_awvalid = 1'b0; bus_if.axil_wvalid = 1'b0; bus_if.axil_arvalid = 1'b0;
        step(1);
        chk("arb1_first_hwrite", bus_if.hwrite, 1'b1);
        chk("arb1_first_haddr", bus_if.haddr, 16'h0400);
        step(2);
        chk("arb1_bvalid", bus_if.axil_bvalid, 1'b1);
        step(2);
        chk("arb1_second_htrans", bus_if.htrans, 2'b10);
        chk("arb1_second_hwrite", bus_if.hwrite, 1'b0);
        chk("arb1_second_haddr", bus_if.haddr, 16'h0500);
        step(2);
        chk("arb1_rvalid", bus_if.axil_rvalid, 1'b1);
        chk("arb1_rdata", bus_if.axil_rdata, 32'h12345678);
        step(1);

        // Second contended pair: read goes first this time
        bus_if.axil_awaddr = 16'h0600; bus_if.axil_awvalid = 1'b1;
        bus_if.axil_wstrb = 4'hF; bus_if.axil_wvalid = 1'b1;
        bus_if.axil_araddr = 16'h0700; bus_if.axil_arvalid = 1'b1;
        step(1);
        bus_if.axil_awvalid = 1'b0; bus_if.axil_wvalid = 1'b0; bus_if.axil_arvalid = 1'b0;
        step(1);
        chk("arb2_first_hwrite", bus_if.hwrite, 1'b0);
        chk("arb2_first_haddr", bus_if.haddr, 16'h0700);
        step(2);
        chk("arb2_rvalid", bus_if.axil_rvalid, 1'b1);
        step(2);
        chk("arb2_second_hwrite", bus_if.hwrite, 1'b1);
        chk("arb2_second_haddr", bus_if.haddr, 16'h0600);
        step(2);
        chk("arb2_bvalid", bus_if.axil_bvalid, 1'b1);
        step(1);

        // Unaligned read address, four wait states in the data phase
        bus_if.axil_rready = 1'b0; bus_if.hrdata = 32'h0;
        bus_if.axil_araddr = 16'h0013; bus_if.axil_arvalid = 1'b1;
        step(1);
        bus_if.axil_arvalid = 1'b0;
        step(1);
        chk("rd_haddr", bus_if.haddr, 16'h0010);
        chk("rd_hsize", bus_if.hsize, 3'b010);
        step(1);
        bus_if.hready = 1'b0;
        step(4);
        chk("rd_rvalid_wait", bus_if.axil_rvalid, 1'b0);
        bus_if.hready = 1'b1; bus_if.hrdata = 32'hDEADBEEF;
        step(1);
        chk("rd_rvalid", bus_if.axil_rvalid, 1'b1);
        chk("rd_rdata", bus_if.axil_rdata, 32'hDEADBEEF);
        chk("rd_rresp", bus_if.axil_rresp, 2'b00);
        bus_if.hrdata = 32'h0BADF00D;
        step(3);
        chk("rd_rvalid_hold", bus_if.axil_rvalid, 1'b1);
        chk("rd_rdata_hold", bus_if.axil_rdata, 32'hDEADBEEF);
        bus_if.axil_rready = 1'b1;
        step(1);
        chk("rd_rvalid_done", bus_if.axil_rvalid, 1'b0);

        // AHB error on a read data phase
        bus_if.axil_araddr = 16'h0020; bus_if.axil_arvalid = 1'b1;
        step(1);
        bus_if.axil_arvalid = 1'b0;
        step(2);
        bus_if.hresp = 2'b01;
        step(1);
        chk("err_rvalid", bus_if.axil_rvalid, 1'b1);
        chk("err_rresp", bus_if.axil_rresp, 2'b10);
        bus_if.hresp = 2'b00;
        step(1);

        // Asynchronous reset in the middle of an address phase
        bus_if.hready = 1'b0;
        bus_if.axil_araddr = 16'h0030; bus_if.axil_arvalid = 1'b1;
        bus_if.axil_wstrb = 4'hF; bus_if.axil_wvalid = 1'b1;
        step(1);
        bus_if.axil_arvalid = 1'b0; bus_if.axil_wvalid = 1'b0;
        step(1);
        chk("ar_hsel_before", bus_if.hsel, 1'b1);
        chk("ar_ready_before", {bus_if.axil_wready, bus_if.axil_arready}, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_hsel_async", bus_if.hsel, 1'b0);
        chk("ar_htrans_async", bus_if.htrans, 2'b00);
        chk("ar_ready_async", {bus_if.axil_awready, bus_if.axil_wready, bus_if.axil_arready}, 3'b111);
        bus_if.hready = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(1);

`ifdef AXIL2AHB_TIMEOUT_EN
        // Watchdog with hready stuck low
        bus_if.hready = 1'b0;
        bus_if.axil_araddr = 16'h0040; bus_if.axil_arvalid = 1'b1;
        step(1);
        bus_if.axil_arvalid = 1'b0;
        step(1);
        step(7);
        chk("to_rvalid_early", bus_if.axil_rvalid, 1'b0);
        step(1);
        chk("to_rvalid", bus_if.axil_rvalid, 1'b1);
        chk("to_rresp", bus_if.axil_rresp, 2'b10);
        chk("to_rdata", bus_if.axil_rdata, 32'h0);
        chk("to_hsel", bus_if.hsel, 1'b0);
        bus_if.hready = 1'b1;
        step(1);
        bus_if.hrdata = 32'h55AA55AA;
        bus_if.axil_araddr = 16'h0050; bus_if.axil_arvalid = 1'b1;
        step(1);
        bus_if.axil_arvalid = 1'b0;
        step(3);
        chk("to_next_rvalid", bus_if.axil_rvalid, 1'b1);
        chk("to_next_rdata", bus_if.axil_rdata, 32'h55AA55AA);
        chk("to_next_rresp", bus_if.axil_rresp, 2'b00);
        step(1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axil2ahb_rr.md
Name: axil2ahb_rr

Overview:
AXI4-Lite slave to AHB-Lite master bridge, next generation of our single-FSM bridge. Buffers AW, W and AR independently and arbitrates reads against writes round-robin. Derives hsize/haddr byte offset from wstrb and maps AHB errors to SLVERR. Sits between the AXI-Lite interconnect and AHB peripheral islands; DWIDTH 32 or 64.

Parameters:
AWIDTH, 16, AXI/AHB address width
DWIDTH, 32, data width; legal values 32 and 64
TIMEOUT_CYCLES, 256, hready-low watchdog limit; used only with AXIL2AHB_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
axil_awaddr/awprot/awvalid/awready  in/in/in/out  AWIDTH/3/1/1  AXI-Lite write address channel
axil_wdata/wstrb/wvalid/wready  in/in/in/out  DWIDTH/DWIDTH/8/1/1  write data channel
axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
axil_araddr/arprot/arvalid/arready  in/in/in/out  AWIDTH/3/1/1  read address channel
axil_rdata/rresp/rvalid/rready  out/out/out/in  DWIDTH/2/1/1  read data channel
haddr/hwdata/hsel/hwrite/htrans/hsize  out  AWIDTH/DWIDTH/1/1/2/3  AHB master outputs
hready/hrdata/hresp  in  1/DWIDTH/2  AHB inputs; hresp!=0 is an error

Behaviour:
- Clock clk; reset rst_n is asynchronous, active-low. Assertion mid-transfer abandons it; all state returns to reset values immediately.
- Reset values: bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, hsel=0, htrans=IDLE(2'b00), haddr=0, hwrite=0, hwdata=0, hsize=log2(DWIDTH/8). Hold registers are empty.
- Skid registers: one entry each for AW, W and AR. The ready signal equals "entry empty" and is registered, so there is no valid-to-ready path. AW and W may arrive in any order or cycle.
- FSM states:
  - IDLE. A write is eligible when AW and W are both held; a read is eligible when AR is held. If both are eligible, grant the opposite of the last_write flag (reset 0, so a write wins first). Go to ADDR, or go straight to RESP for a write with no AHB transfer.
  - ADDR: hsel=1, htrans=NONSEQ, haddr/hwrite/hsize valid. On hready go to DATA and set htrans=IDLE, hsel=0.
  - DATA: hwdata holds the W entry. On hready capture hrdata (reads) and set resp = (hresp!=0) ? SLVERR : OKAY. Free the used hold entries, assert bvalid or rvalid, go to RESP.
  - RESP: wait for bready or rready, then return to IDLE. Only one transfer is outstanding. New AW/W/AR are still accepted into empty hold slots.
- Write sizing from wstrb, by byte count:
  - 1, 2 aligned pairs, 4 aligned quads, or all bytes (8 for 64-bit): hsize = log2(count), haddr low bits = index of the lowest set strobe, upper bits from awaddr.
  - wstrb==0: no AHB transfer, bresp=OKAY.
  - Any other pattern: no AHB transfer, bresp=SLVERR.
- Reads are always full width: hsize=log2(DWIDTH/8), haddr low log2(DWIDTH/8) bits forced to 0. rdata holds its value while rvalid=1.
- Latency with hready=1 throughout: bvalid or rvalid rises 3 clk edges after the last of the required channel handshakes.
- awprot and arprot are ignored.

Optional Feature:
- Macro: AXIL2AHB_TIMEOUT_EN.
- Defined: a counter runs in ADDR/DATA while hready=0 and clears whenever hready=1. On reaching TIMEOUT_CYCLES the FSM forces htrans=IDLE, hsel=0, responds SLVERR (rdata=0), frees the entries and goes to RESP.
- Undefined: the counter is not built and the bridge waits on hready indefinitely.

Decomposition:
- Package axil2ahb_pkg holds:
  - the state enum (IDLE, ADDR, DATA, RESP);
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10;
  - HTRANS_IDLE=2'b00 and HTRANS_NONSEQ=2'b10;
  - HSIZE_BYTE/HALF/WORD/DWORD.
- Sub-module axil2ahb_strb_decode: purely combinational, wstrb to {legal, zero, hsize, byte_offset}, parameterised by DWIDTH.

Test Plan:
- DWIDTH=32, AW addr 0x0100 and W wstrb=4'hF in the same cycle, hready=1 -> haddr=0x0100, hsize=3'b010, hwrite=1, NONSEQ for one cycle, bvalid 3 edges later, bresp=0.
- W (wstrb=4'h4) three cycles before AW addr 0x0200 -> haddr=0x0202, hsize=3'b000; wstrb=4'h5 -> no htrans NONSEQ, bresp=2'b10.
- AW+W and AR all held in IDLE after reset -> write is issued first, then the read; a second simultaneous pair -> read issued first.
- Read 0x0013 with hrdata=0xDEADBEEF and hready low for 4 cycles in DATA -> haddr=0x0010, rdata=0xDEADBEEF, rresp=0, stable until rready.
- hresp=ERROR on a read data phase -> rresp=2'b10. rst_n dropped during ADDR -> hsel=0, htrans=0 and all ready signals reset asynchronously.
- With AXIL2AHB_TIMEOUT_EN and TIMEOUT_CYCLES=8, hready held 0 -> SLVERR response after 8 cycles, bridge accepts the next transaction.
